// File: rtl/arq_pkg.sv
// Shared definitions for the issue stage: opcodes, FSM states, register
// geometry and the opcode classifier used by the hazard logic.
package arq_pkg;

    localparam int NUM_REGS  = 8;
    localparam int REG_W     = 3;
    localparam int NUM_BANKS = 2;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_STR = 4'h9;
    localparam logic [3:0] OP_BR  = 4'hE;

    typedef enum logic [1:0] {
        RUN,
        BR_WAIT,
        FLUSH
    } issue_state_t;

    // Which operand fields an opcode actually uses.
    typedef struct packed {
        logic rd_sa;
        logic rd_sb;
        logic wr_d;
    } op_class_t;

    // Instruction fields carried through the issue register.
    typedef struct packed {
        logic [3:0]       op;
        logic             cond;
        logic             rvd;
        logic             rvs;
        logic [REG_W-1:0] rnd;
        logic [REG_W-1:0] rnsa;
        logic [REG_W-1:0] rnsb;
    } issue_fields_t;

    function automatic op_class_t classify(input logic [3:0] op);
        op_class_t c;
        case (op)
            OP_NOP:  c = '{rd_sa: 1'b0, rd_sb: 1'b0, wr_d: 1'b0};
            OP_STR:  c = '{rd_sa: 1'b1, rd_sb: 1'b1, wr_d: 1'b0};
            OP_BR:   c = '{rd_sa: 1'b1, rd_sb: 1'b0, wr_d: 1'b0};
            default: c = '{rd_sa: 1'b1, rd_sb: 1'b1, wr_d: 1'b1};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// Pending-write scoreboard: one bit per register in the scalar and vector
// banks. Set by issue, cleared by writeback, with three combinational
// lookup ports for source A, source B and destination.
module scoreboard
    import arq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic             set_vec,
    input  logic [REG_W-1:0] set_reg,
    input  logic             clr_en,
    input  logic             clr_vec,
    input  logic [REG_W-1:0] clr_reg,
    input  logic             a_vec,
    input  logic [REG_W-1:0] a_reg,
    output logic             a_pend,
    input  logic             b_vec,
    input  logic [REG_W-1:0] b_reg,
    output logic             b_pend,
    input  logic             d_vec,
    input  logic [REG_W-1:0] d_reg,
    output logic             d_pend
);

    // Index is {bank, register}: bits 0..7 scalar, 8..15 vector.
    logic [NUM_BANKS*NUM_REGS-1:0] pend_q, pend_d;

    // Next-state of the pending array: clear on writeback, then set on issue.
    always_comb begin
        pend_d = pend_q;
        if (clr_en) begin
            pend_d[{clr_vec, clr_reg}] = 1'b0;
        end
        // NOTE: the set is applied after the clear so that an issue and a
        // writeback to the same register in one cycle leaves it pending.
        if (set_en) begin
            pend_d[{set_vec, set_reg}] = 1'b1;
        end
    end

    // Pending-array register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: the array is only 16 flops, so it is reset like any other
        // state; a stale pending bit after reset would deadlock decode.
        if (rst) begin
            pend_q <= '0;
        end else begin
            // NOTE: sequential state is always written with <= so every flop
            // samples pre-edge values regardless of block ordering.
            pend_q <= pend_d;
        end
    end

    assign a_pend = pend_q[{a_vec, a_reg}];
    assign b_pend = pend_q[{b_vec, b_reg}];
    assign d_pend = pend_q[{d_vec, d_reg}];

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: hazard detection against the pending-write scoreboard,
// branch serialisation FSM, one-cycle issue register and a saturating
// stall counter.
// Optional feature: define ISSUE_CTRL_BYPASS_EN to let a same-cycle
// writeback mask the hazard it resolves.
module issue_ctrl
    import arq_pkg::*;
#(
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dec_valid,
    output logic               dec_ready,
    input  logic [3:0]         dec_op,
    input  logic               dec_cond,
    input  logic               dec_RvD,
    input  logic               dec_RvS,
    input  logic [REG_W-1:0]   dec_RnD,
    input  logic [REG_W-1:0]   dec_RnSA,
    input  logic [REG_W-1:0]   dec_RnSB,
    output logic               iss_valid,
    output logic [3:0]         iss_op,
    output logic               iss_cond,
    output logic               iss_RvD,
    output logic               iss_RvS,
    output logic [REG_W-1:0]   iss_RnD,
    output logic [REG_W-1:0]   iss_RnSA,
    output logic [REG_W-1:0]   iss_RnSB,
    input  logic               wb_valid,
    input  logic               wb_vec,
    input  logic [REG_W-1:0]   wb_reg,
    input  logic               br_done,
    input  logic               br_taken,
    output logic               flush,
    output logic [STALL_W-1:0] stall_cnt
);

    issue_state_t  state_q, state_d;
    issue_fields_t iss_q;
    logic          iss_valid_q;
    logic          flush_q;
    logic [STALL_W-1:0] stall_cnt_q;

    op_class_t cls;
    logic      sa_pend, sb_pend, d_pend;
    logic      sa_byp, sb_byp, d_byp;
    logic      hazard;
    logic      accept;
    logic      is_ctrl;

    assign cls     = classify(dec_op);
    assign is_ctrl = (dec_op == OP_BR) || dec_cond;
    assign accept  = dec_valid && dec_ready;

    scoreboard u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (accept && cls.wr_d),
        .set_vec (dec_RvD),
        .set_reg (dec_RnD),
        .clr_en  (wb_valid),
        .clr_vec (wb_vec),
        .clr_reg (wb_reg),
        .a_vec   (dec_RvS),
        .a_reg   (dec_RnSA),
        .a_pend  (sa_pend),
        .b_vec   (dec_RvS),
        .b_reg   (dec_RnSB),
        .b_pend  (sb_pend),
        .d_vec   (dec_RvD),
        .d_reg   (dec_RnD),
        .d_pend  (d_pend)
    );

`ifdef ISSUE_CTRL_BYPASS_EN
    // A writeback landing this cycle already satisfies the dependency.
    assign sa_byp = wb_valid && (wb_vec == dec_RvS) && (wb_reg == dec_RnSA);
    assign sb_byp = wb_valid && (wb_vec == dec_RvS) && (wb_reg == dec_RnSB);
    assign d_byp  = wb_valid && (wb_vec == dec_RvD) && (wb_reg == dec_RnD);
`else
    assign sa_byp = 1'b0;
    assign sb_byp = 1'b0;
    assign d_byp  = 1'b0;
`endif

    assign hazard = (cls.rd_sa && sa_pend && !sa_byp)
                 || (cls.rd_sb && sb_pend && !sb_byp)
                 || (cls.wr_d  && d_pend  && !d_byp);

    // FSM next-state and decode handshake.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        dec_ready = 1'b0;
        case (state_q)
            RUN: begin
                dec_ready = !hazard;
                if (dec_valid && !hazard && is_ctrl) begin
                    state_d = BR_WAIT;
                end
            end
            BR_WAIT: begin
                if (br_done) begin
                    state_d = br_taken ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // FSM state and flush pulse registers; flush is high exactly while in FLUSH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= (state_d == FLUSH);
        end
    end

    // Issue register: loads accepted fields, valid only the cycle after accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid_q <= 1'b0;
            iss_q       <= '0;
        end else begin
            iss_valid_q <= accept;
            if (accept) begin
                iss_q <= '{op: dec_op, cond: dec_cond, rvd: dec_RvD, rvs: dec_RvS,
                           rnd: dec_RnD, rnsa: dec_RnSA, rnsb: dec_RnSB};
            end
        end
    end

    // Saturating count of cycles where decode is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (dec_valid && !dec_ready && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + {{(STALL_W-1){1'b0}}, 1'b1};
        end
    end

    assign iss_valid = iss_valid_q;
    assign iss_op    = iss_q.op;
    assign iss_cond  = iss_q.cond;
    assign iss_RvD   = iss_q.rvd;
    assign iss_RvS   = iss_q.rvs;
    assign iss_RnD   = iss_q.rnd;
    assign iss_RnSA  = iss_q.rnsa;
    assign iss_RnSB  = iss_q.rnsb;
    assign flush     = flush_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/issue_ctrl.md
# issue_ctrl

Issue controller between the instruction decoder and the execution datapath of the scalar/vector processor. It holds a 2×8 scoreboard of pending destination writes (scalar bank, vector bank) and stalls decode on RAW/WAW hazards. It serialises control flow by blocking issue while a conditional/branch instruction resolves. Accepted instructions are forwarded to execute through a one-cycle issue register, and the block keeps a saturating stall counter for performance measurement.

## Interface
- `STALL_W`, 16: width of stall performance counter
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `dec_valid`  in  1  decoder presents an instruction
- `dec_ready`  out  1  combinational; instruction accepted this cycle when `dec_valid && dec_ready`
- `dec_op`  in  4  opcode
- `dec_cond`  in  1  conditional-execution flag
- `dec_RvD`, `dec_RvS`  in  1 each  destination / source operands are vector-bank registers
- `dec_RnD`, `dec_RnSA`, `dec_RnSB`  in  3 each  destination, source A, source B register numbers
- `iss_valid`  out  1  registered; instruction in issue register is valid for execute
- `iss_op`  out  4; `iss_cond`, `iss_RvD`, `iss_RvS` out 1; `iss_RnD`, `iss_RnSA`, `iss_RnSB` out 3  registered copies of accepted fields
- `wb_valid`  in  1  writeback completes this cycle
- `wb_vec`  in  1  writeback targets vector bank
- `wb_reg`  in  3  writeback register number
- `br_done`  in  1  pending branch/conditional resolved (one-cycle pulse)
- `br_taken`  in  1  qualified by `br_done`; control flow redirected
- `flush`  out  1  registered; one-cycle pulse, decode/fetch discard in-flight instruction
- `stall_cnt`  out  `STALL_W`  saturating count of cycles with `dec_valid && !dec_ready`

## Operation
- Classification from `dec_op`: `OP_NOP` reads and writes nothing; `OP_STR` reads SA, SB and writes nothing; `OP_BR` reads SA and writes nothing. All other ops read SA and SB and write D.
- Control instruction: `dec_op == OP_BR` or `dec_cond == 1`.
- Hazard: `pend[dec_RvS][dec_RnSA]` or `pend[dec_RvS][dec_RnSB]` for each source actually read, or, when the op writes, `pend[dec_RvD][dec_RnD]`.
- FSM states are `RUN`, `BR_WAIT`, and `FLUSH`.
  - `RUN`: `dec_ready = !hazard`. On accept, the issue register loads the fields. If the op writes, `pend[RvD][RnD]` is set. A control instruction moves the FSM to `BR_WAIT`.
  - `BR_WAIT`: `dec_ready = 0`. On `br_done && br_taken`, go to `FLUSH`. On `br_done && !br_taken`, go to `RUN`.
  - `FLUSH`: `flush = 1` for exactly this state's cycle and `dec_ready = 0`; the next state is `RUN`.
- Writeback: on `wb_valid`, `pend[wb_vec][wb_reg]` clears at the clock edge. If an issue sets the same bit in the same cycle, the set wins.
- A writeback to a non-pending register is ignored; no error.
- `br_done` outside `BR_WAIT` is ignored.
- `stall_cnt` increments when `dec_valid && !dec_ready` and holds at all-ones.

## Timing
- Issue latency is 1 cycle: accept at edge N, `iss_valid = 1` during cycle N+1. `iss_valid` drops the cycle after no accept occurs.
- `dec_ready` is combinational from the inputs, the scoreboard, and the FSM state; it has no dependence on `dec_valid`.
- The earliest issue after a taken branch resolves is 2 cycles after `br_done` (one `FLUSH` cycle, then `RUN`). For a not-taken branch it is the next cycle.
- Reset (synchronous, any state, including `BR_WAIT` and `FLUSH`):
  - FSM goes to `RUN` and `pend` is cleared to all-zero.
  - `iss_valid = 0`, all `iss_*` fields = 0, `flush = 0`, `stall_cnt = 0`.
  - `dec_ready` is 1 the cycle after reset deasserts, given no hazard.

## Configuration
- `ISSUE_CTRL_BYPASS_EN` defined: a same-cycle `wb_valid` matching a pending source or destination masks that hazard combinationally, so dependent instructions issue in the writeback cycle.
- Undefined: the hazard clears only after the writeback edge, one cycle later.
- `dec_ready` depends combinationally on `wb_*` only when the macro is defined.

## Structure
- Shared package `arq_pkg`:
  - opcode constants `OP_NOP = 4'h0`, `OP_STR = 4'h9`, `OP_BR = 4'hE`
  - `typedef enum logic [1:0] {RUN, BR_WAIT, FLUSH} issue_state_t`
  - `NUM_REGS = 8`
- One sub-module, `scoreboard`: a 2×8 pending-bit array with set/clear ports and three combinational lookup ports.
- The FSM, issue register, and counter stay in `issue_ctrl`.

## Test plan
- **RAW stall:** Issue `op=1, RvD=0, RnD=3`, then `op=2, RvS=0, RnSA=3`. Required: `dec_ready = 0` and `stall_cnt` increments until `wb_valid=1, wb_vec=0, wb_reg=3`; the dependent instruction then issues the next cycle (the same cycle with the bypass macro defined).
- **Bank isolation:** Pending scalar r5, then issue `RvS=1, RnSA=5`. Required: no stall.
- **Taken branch:** Issue `op=OP_BR`, then hold `dec_valid`. Required: `dec_ready = 0` until `br_done=1, br_taken=1`; `flush = 1` for exactly one cycle; issue resumes 2 cycles after `br_done`.
- **Not-taken conditional:** Issue `op=1, cond=1`, then `br_done=1, br_taken=0`. Required: no `flush`; issue resumes the next cycle.
- **Set/clear collision:** Pending vector r2, then the same cycle brings `wb_valid` for v2 and an accept of `op=1, RvD=1, RnD=2`. Required: v2 remains pending.
- **Reset mid-`BR_WAIT` and counter saturation:** Assert `rst` during `BR_WAIT` with r1 pending. Required: all outputs are zero, `pend` is empty, and `dec_ready = 1` afterwards. With `STALL_W=4`, 20 stall cycles leave `stall_cnt = 4'hF`.
